// File: rtl/calc_pkg.sv
// calc_pkg: opcode, error-code and FSM state enums shared by rpn_exec and calc_alu
package calc_pkg;
  typedef enum logic [2:0] {OP_PUSH, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR, OP_RSV} op_e;
  typedef enum logic [1:0] {ERR_OK, ERR_UNDER, ERR_FULL, ERR_ILL} err_e;
  typedef enum logic [2:0] {S_IDLE, S_POP, S_EXEC, S_PUSH, S_RESP} state_e;
endpackage

// File: rtl/rpn_exec_if.sv
// rpn_exec_if: command/response bundle; master issues cmd_* and sees rsp_*, slave is the executor
interface rpn_exec_if #(parameter int WIDTH = 36);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic [1:0]       rsp_err;
  logic             rsp_aovf;
  modport master (output cmd_valid, cmd_op, cmd_data, input cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_aovf);
  modport slave  (input cmd_valid, cmd_op, cmd_data, output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_aovf);
endinterface

// File: rtl/calc_alu.sv
// calc_alu: combinational datapath, result = a OP b (a = older entry, b = top), aovf = signed ADD/SUB overflow
module calc_alu
  import calc_pkg::*;
#(
  parameter int WIDTH = 36
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             aovf
);
  logic [WIDTH-1:0] sum, dif, shl, shr;
  logic [5:0] sh;
  logic big;
  always_comb begin
    sh = b[5:0];
    big = int'(sh) >= WIDTH;
    sum = a + b;
    dif = a - b;
    shl = big ? '0 : a << sh;
    shr = big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> sh);
    result = op == OP_ADD ? sum :
             op == OP_SUB ? dif :
             op == OP_AND ? (a & b) :
             op == OP_OR  ? (a | b) :
             op == OP_SHL ? shl :
             op == OP_SHR ? shr : '0;
    aovf = op == OP_ADD ? (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]) :
           op == OP_SUB ? (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]) : 1'b0;
  end
endmodule

// File: rtl/rpn_exec.sv
// rpn_exec: RPN command executor driving an external stack; ports clk, reset, bus (cmd/rsp), stk_push/stk_pop/stk_d out, stk_q1/stk_q2/stk_ptr in
module rpn_exec
  import calc_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  rpn_exec_if.slave        bus,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_d,
  input  logic [WIDTH-1:0] stk_q1,
  input  logic [WIDTH-1:0] stk_q2,
  input  logic [9:0]       stk_ptr
);
  state_e state_q;
  op_e op_q, op_in;
  logic aovf_q, alu_aovf;
  logic [WIDTH-1:0] alu_res;
  assign op_in = op_e'(bus.cmd_op);
  calc_alu #(.WIDTH(WIDTH)) u_alu (
    .op    (op_q),
    .a     (stk_q2),
    .b     (stk_q1),
    .result(alu_res),
    .aovf  (alu_aovf)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      op_q          <= OP_PUSH;
      aovf_q        <= 1'b0;
      bus.cmd_ready <= 1'b1;
      stk_push      <= 1'b0;
      stk_pop       <= 1'b0;
      stk_d         <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= ERR_OK;
      bus.rsp_aovf  <= 1'b0;
    end else begin
      stk_push      <= 1'b0;
      stk_pop       <= 1'b0;
      bus.rsp_valid <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.cmd_valid && bus.cmd_ready) begin
          bus.cmd_ready <= 1'b0;
          op_q          <= op_in;
          aovf_q        <= 1'b0;
          if (op_in == OP_RSV || (op_in == OP_PUSH ? int'(stk_ptr) >= DEPTH - 1 : int'(stk_ptr) < 2)) begin
            state_q       <= S_RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= '0;
            bus.rsp_aovf  <= 1'b0;
            bus.rsp_err   <= op_in == OP_RSV ? ERR_ILL : op_in == OP_PUSH ? ERR_FULL : ERR_UNDER;
          end else if (op_in == OP_PUSH) begin
            state_q  <= S_PUSH;
            stk_push <= 1'b1;
            stk_d    <= bus.cmd_data;
          end else begin
            state_q <= S_POP;
            stk_pop <= 1'b1;
          end
        end
        S_POP: state_q <= S_EXEC;
        S_EXEC: begin
          state_q  <= S_PUSH;
          stk_push <= 1'b1;
          stk_d    <= alu_res;
          aovf_q   <= alu_aovf;
        end
        S_PUSH: begin
          state_q       <= S_RESP;
          bus.rsp_valid <= 1'b1;
          bus.rsp_data  <= stk_d;
          bus.rsp_err   <= ERR_OK;
          bus.rsp_aovf  <= aovf_q;
        end
        default: begin
          state_q       <= S_IDLE;
          bus.cmd_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rpn_exec.sv
// tb_rpn_exec: table, directed and random checks of rpn_exec against a queue-based reference
module tb_rpn_exec;
  localparam int W = 36;
  localparam int D = 10;
  localparam logic [W-1:0] M1 = -1;
  localparam logic [W-1:0] M2 = -2;
  localparam logic [W-1:0] M8 = -8;
  localparam logic [W-1:0] M16 = -16;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  rpn_exec_if #(.WIDTH(W)) bus ();
  logic stk_push, stk_pop;
  logic [W-1:0] stk_d, stk_q1, stk_q2;
  logic [9:0] stk_ptr;
  logic [W-1:0] mem[D];
  rpn_exec #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .bus(bus), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_d(stk_d), .stk_q1(stk_q1), .stk_q2(stk_q2), .stk_ptr(stk_ptr)
  );
  always @(posedge clk) begin
    if (reset) stk_ptr <= 0;
    else if (stk_push) begin
      mem[stk_ptr] <= stk_d;
      stk_ptr <= stk_ptr + 1;
    end else if (stk_pop) begin
      stk_q1 <= mem[stk_ptr-1];
      stk_q2 <= mem[stk_ptr-2];
      stk_ptr <= stk_ptr - 2;
    end
  end
  int vecs = 0;
  int errs = 0;
  logic [W-1:0] mq[$];
  typedef struct {
    logic [2:0] op;
    logic [W-1:0] data;
    logic [W-1:0] ed;
    logic [1:0] ee;
    logic ea;
    int ep;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  task automatic add(input logic [2:0] op, input logic [W-1:0] data, input logic [W-1:0] ed,
                     input logic [1:0] ee, input logic ea, input int ep);
    tbl.push_back('{op, data, ed, ee, ea, ep});
  endtask
  task automatic model(input logic [2:0] op, input logic [W-1:0] data, output logic [W-1:0] ed,
                       output logic [1:0] ee, output logic ea);
    longint la, lb, r, mx, mn;
    logic [W-1:0] a, b;
    int amt;
    ed = 0; ee = 0; ea = 0;
    mx = (longint'(1) << (W - 1)) - 1;
    mn = -(longint'(1) << (W - 1));
    if (op == 7) ee = 3;
    else if (op == 0) begin
      if (mq.size() >= D - 1) ee = 2;
      else begin
        ed = data;
        mq.push_back(data);
      end
    end else if (mq.size() < 2) ee = 1;
    else begin
      b = mq.pop_back();
      a = mq.pop_back();
      la = longint'($signed(a));
      lb = longint'($signed(b));
      amt = int'(b[5:0]);
      case (op)
        1: r = la + lb;
        2: r = la - lb;
        3: r = la & lb;
        4: r = la | lb;
        5: r = la << amt;
        default: r = la >>> amt;
      endcase
      if (op == 1 || op == 2) ea = r > mx || r < mn;
      ed = r[W-1:0];
      mq.push_back(ed);
    end
  endtask
  task automatic run(input logic [2:0] op, input logic [W-1:0] data, output logic [W-1:0] rd,
                     output logic [1:0] re, output logic ra, output int lat, output int plat,
                     output bit popped);
    bit both;
    int n;
    both = 0; popped = 0; plat = 0; n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.cmd_valid = 1;
    bus.cmd_op = op;
    bus.cmd_data = data;
    @(posedge clk);
    #1;
    bus.cmd_valid = 0;
    lat = 1;
    while (!bus.rsp_valid && lat < 12) begin
      both |= stk_push && stk_pop;
      if (stk_push && plat == 0) plat = lat;
      popped |= stk_pop;
      @(posedge clk);
      #1;
      lat++;
    end
    rd = bus.rsp_data;
    re = bus.rsp_err;
    ra = bus.rsp_aovf;
    chk("both_strobes", 64'(both), 0);
    @(posedge clk);
    #1;
    chk("rsp_pulse_len", 64'(bus.rsp_valid), 0);
  endtask
  task automatic apply(input string t, input logic [2:0] op, input logic [W-1:0] data,
                       input logic [W-1:0] ed, input logic [1:0] ee, input logic ea, input int ep);
    logic [W-1:0] rd;
    logic [1:0] re;
    logic ra;
    int lat, plat;
    bit popped;
    run(op, data, rd, re, ra, lat, plat, popped);
    chk({t, " data"}, 64'(rd), 64'(ed));
    chk({t, " err"}, 64'(re), 64'(ee));
    chk({t, " aovf"}, 64'(ra), 64'(ea));
    chk({t, " latency"}, 64'(lat), ee != 0 ? 1 : op == 0 ? 2 : 4);
    chk({t, " push_cycle"}, 64'(plat), ee != 0 ? 0 : op == 0 ? 1 : 3);
    chk({t, " popped"}, 64'(popped), 64'(ee == 0 && op != 0));
    chk({t, " ptr"}, 64'(stk_ptr), 64'(ep));
    chk({t, " hold"}, 64'(bus.rsp_data), 64'(ed));
  endtask
  task automatic do_reset();
    reset = 1;
    bus.cmd_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    mq.delete();
  endtask
  initial begin
    logic [2:0] op;
    logic [W-1:0] data, ed;
    logic [1:0] ee;
    logic ea;
    bus.cmd_valid = 0;
    bus.cmd_op = 0;
    bus.cmd_data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst cmd_ready", 64'(bus.cmd_ready), 1);
    chk("rst stk_push", 64'(stk_push), 0);
    chk("rst stk_pop", 64'(stk_pop), 0);
    chk("rst stk_d", 64'(stk_d), 0);
    chk("rst rsp_valid", 64'(bus.rsp_valid), 0);
    chk("rst rsp_data", 64'(bus.rsp_data), 0);
    chk("rst rsp_err", 64'(bus.rsp_err), 0);
    chk("rst rsp_aovf", 64'(bus.rsp_aovf), 0);
    bus.cmd_valid = 1;
    bus.cmd_op = 0;
    bus.cmd_data = 77;
    @(posedge clk);
    #1;
    chk("rst_prio stk_push", 64'(stk_push), 0);
    chk("rst_prio cmd_ready", 64'(bus.cmd_ready), 1);
    chk("rst_prio rsp_valid", 64'(bus.rsp_valid), 0);
    bus.cmd_valid = 0;
    reset = 0;
    add(0, 5, 5, 0, 0, 1);
    add(0, 3, 3, 0, 0, 2);
    add(1, 0, 8, 0, 0, 1);
    add(0, 3, 3, 0, 0, 2);
    add(0, 5, 5, 0, 0, 3);
    add(2, 0, M2, 0, 0, 2);
    add(1, 0, 6, 0, 0, 1);
    add(0, 36'h7FFFFFFFF, 36'h7FFFFFFFF, 0, 0, 2);
    add(0, 1, 1, 0, 0, 3);
    add(1, 0, 36'h800000000, 0, 1, 2);
    add(3, 0, 0, 0, 0, 1);
    add(0, M8, M8, 0, 0, 2);
    add(0, 2, 2, 0, 0, 3);
    add(6, 0, M2, 0, 0, 2);
    add(4, 0, M2, 0, 0, 1);
    add(7, 0, 0, 3, 0, 1);
    add(1, 0, 0, 1, 0, 1);
    add(0, 3, 3, 0, 0, 2);
    add(5, 0, M16, 0, 0, 1);
    add(0, 40, 40, 0, 0, 2);
    add(6, 0, M1, 0, 0, 1);
    add(0, 63, 63, 0, 0, 2);
    add(5, 0, 0, 0, 0, 1);
    add(0, 36'h800000000, 36'h800000000, 0, 0, 2);
    add(0, 1, 1, 0, 0, 3);
    add(2, 0, 36'h7FFFFFFFF, 0, 1, 2);
    foreach (tbl[i]) apply($sformatf("tbl%0d", i), tbl[i].op, tbl[i].data, tbl[i].ed, tbl[i].ee, tbl[i].ea, tbl[i].ep);
    do_reset();
    apply("empty_add", 1, 0, 0, 1, 0, 0);
    do_reset();
    for (int i = 0; i < 9; i++) apply($sformatf("fill%0d", i), 0, W'(i + 100), W'(i + 100), 0, 0, i + 1);
    apply("full_push", 0, 55, 0, 2, 0, 9);
    do_reset();
    apply("abort_p1", 0, 1, 1, 0, 0, 1);
    apply("abort_p2", 0, 2, 2, 0, 0, 2);
    @(negedge clk);
    bus.cmd_valid = 1;
    bus.cmd_op = 1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 0;
    @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk);
    #1;
    chk("abort stk_push", 64'(stk_push), 0);
    chk("abort rsp_valid", 64'(bus.rsp_valid), 0);
    reset = 0;
    mq.delete();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) chk("abort cmd_ready", 64'(bus.cmd_ready), 1);
      chk($sformatf("abort quiet%0d", i), 64'({stk_push, stk_pop, bus.rsp_valid}), 0);
    end
    apply("abort_after", 0, 7, 7, 0, 0, 1);
    do_reset();
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 1) == 0 ? 3'd0 : 3'($urandom_range(1, 7));
      data = $urandom_range(0, 3) == 0 ? W'($urandom_range(0, 63)) : {4'($urandom), $urandom};
      model(op, data, ed, ee, ea);
      apply($sformatf("rnd%0d", i), op, data, ed, ee, ea, mq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/rpn_exec.md
RPN_EXEC -- requirements
Module: rpn_exec

Interface
REQ-001 Parameter WIDTH, default 36, operand/result width (signed two's complement).
REQ-002 Parameter DEPTH, default 10, number of entries in the attached stack.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_op  input  3  opcode: 000 PUSH, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 SHL, 110 SHR, 111 reserved.
REQ-008 cmd_data  input  WIDTH  immediate operand for PUSH; ignored otherwise.
REQ-009 stk_push  output  1  push strobe to stack.
REQ-010 stk_pop  output  1  pop strobe to stack.
REQ-011 stk_d  output  WIDTH  data written on push.
REQ-012 stk_q1  input  WIDTH  top entry returned by pop.
REQ-013 stk_q2  input  WIDTH  second entry returned by pop.
REQ-014 stk_ptr  input  10  current stack occupancy.
REQ-015 rsp_valid  output  1  one-cycle completion pulse.
REQ-016 rsp_data  output  WIDTH  value pushed (or 0 on error).
REQ-017 rsp_err  output  2  00 ok, 01 underflow, 10 stack full, 11 illegal op.
REQ-018 rsp_aovf  output  1  signed overflow on ADD/SUB.

Function
REQ-019 FSM states IDLE, POP, EXEC, PUSH, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-020 Command accepted on the edge where cmd_valid && cmd_ready; op, data and stk_ptr are captured on that edge.
REQ-021 PUSH with stk_ptr < DEPTH-1: IDLE -> PUSH; stk_push=1, stk_d=cmd_data for one cycle; then RESP.
REQ-022 Binary op with stk_ptr >= 2: IDLE -> POP (stk_pop=1, one cycle) -> EXEC (register result from stk_q1/stk_q2) -> PUSH (stk_push=1, stk_d=result) -> RESP.
REQ-023 Operand order: result = q2 OP q1 (q2 = older entry, q1 = top).
REQ-024 ADD/SUB wrap to WIDTH bits; rsp_aovf=1 when the signed result overflows.
REQ-025 SHL: q2 << q1[5:0], zero fill; SHR: arithmetic q2 >>> q1[5:0]; shift amounts >= WIDTH give 0 (SHL) or sign fill (SHR).
REQ-026 AND/OR bitwise; rsp_aovf=0 for all ops other than ADD/SUB.
REQ-027 Binary op with stk_ptr < 2: no pop, no push; IDLE -> RESP with rsp_err=01.
REQ-028 PUSH with stk_ptr >= DEPTH-1: no push; IDLE -> RESP with rsp_err=10.
REQ-029 Opcode 111: no stack access; IDLE -> RESP with rsp_err=11.
REQ-030 RESP: rsp_valid=1 for exactly one cycle with rsp_data/rsp_err/rsp_aovf; next state IDLE.
REQ-031 Latency accept-to-rsp_valid: PUSH 2 cycles, binary op 4 cycles, error 1 cycle.
REQ-032 stk_push and stk_pop SHALL never be asserted in the same cycle; both are 0 outside PUSH/POP.
REQ-033 rsp_data, rsp_err, rsp_aovf hold their last values until the next RESP.
REQ-034 cmd_valid while not ready is ignored; no queueing.

Reset
REQ-035 reset SHALL force IDLE, cmd_ready=1, stk_push=0, stk_pop=0, stk_d=0, rsp_valid=0, rsp_data=0, rsp_err=00, rsp_aovf=0.
REQ-036 reset asserted mid-command SHALL abort it: no further stack strobes, no rsp_valid.
REQ-037 reset has priority over a simultaneous cmd_valid.

Structure
REQ-038 Package calc_pkg SHALL hold the opcode enum, error-code enum and FSM state enum.
REQ-039 Combinational datapath SHALL be sub-module calc_alu (inputs op, a=q2, b=q1; outputs result, aovf).
REQ-040 rpn_exec SHALL connect directly to the existing stack with the same WIDTH/DEPTH, clk and reset.

Verification
REQ-041 PUSH 5, PUSH 3, ADD -> stk_d=8 pushed 3 cycles after ADD accept, rsp_valid at cycle 4, rsp_err=00, stk_ptr ends 1.
REQ-042 PUSH 3, PUSH 5, SUB -> rsp_data=-2; PUSH 0x7FFFFFFFF, PUSH 1, ADD -> rsp_data=0x800000000, rsp_aovf=1.
REQ-043 Empty stack, ADD -> rsp_err=01 one cycle after accept, no stk_pop, stk_ptr stays 0.
REQ-044 Nine PUSHes then tenth PUSH -> tenth rsp_err=10, no stk_push, stk_ptr stays 9.
REQ-045 PUSH -8, PUSH 2, SHR -> rsp_data=-2; opcode 111 -> rsp_err=11.
REQ-046 reset asserted during EXEC of ADD -> no stk_push, no rsp_valid, cmd_ready=1 the cycle after reset deasserts.
